// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with an integrated pixel-clock-enable divider.
// Every output is registered and decoded from the next counter values, so outputs change on the same edge as the counters.
module vga_timing_gen #(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          h_sync,
    output logic          v_sync,
    output logic          video_on,
    output logic [CW-1:0] x_loc,
    output logic [CW-1:0] y_loc,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEGIN = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEGIN = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          video_on_q, video_on_d;
    logic          pix_tick_q, pix_tick_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          advance;
    logic [31:0]   x_ext, y_ext;

    always_comb begin
        advance = enable && (div_q == DIV_LAST);
        div_d   = div_q;
        x_d     = x_q;
        y_d     = y_q;

        if (enable) begin
            div_d = advance ? '0 : div_q + 1'b1;
        end

        if (advance) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        // Decode in 32 bits so a sync window ending exactly at 2^CW cannot alias to 0.
        x_ext = 32'(x_d);
        y_ext = 32'(y_d);

        h_sync_d      = (x_ext >= HS_BEGIN && x_ext < HS_END) ? HS_POL : ~HS_POL;
        v_sync_d      = (y_ext >= VS_BEGIN && y_ext < VS_END) ? VS_POL : ~VS_POL;
        video_on_d    = (x_ext < H_ACTIVE) && (y_ext < V_ACTIVE);
        pix_tick_d    = advance;
        line_start_d  = advance && (x_d == '0);
        frame_start_d = advance && (x_d == '0) && (y_d == '0);
    end

    // Reset parks the raster on the last position so the first advance wraps to (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            h_sync_q      <= ~HS_POL;
            v_sync_q      <= ~VS_POL;
            video_on_q    <= 1'b0;
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            video_on_q    <= video_on_d;
            pix_tick_q    <= pix_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign video_on    = video_on_q;
    assign x_loc       = x_q;
    assign y_loc       = y_q;
    assign pix_tick    = pix_tick_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small, CLK_DIV=1/HS_POL=1 and default instances share clock, reset and enable.
// Expected raster state is computed from the count of enabled clocks since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        hs;
        logic        vs;
        logic        vo;
        logic        pt;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    logic       hs_s, vs_s, vo_s, pt_s, ls_s, fs_s;
    logic [4:0] x_s, y_s;
    logic       hs_1, vs_1, vo_1, pt_1, ls_1, fs_1;
    logic [4:0] x_1, y_1;
    logic       hs_d, vs_d, vo_d, pt_d, ls_d, fs_d;
    logic [9:0] x_d, y_d;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int e     = 0;
    bit stepped = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(5)
    ) u_small (
        .clk(clk), .reset(rst), .enable(en),
        .h_sync(hs_s), .v_sync(vs_s), .video_on(vo_s),
        .x_loc(x_s), .y_loc(y_s),
        .pix_tick(pt_s), .line_start(ls_s), .frame_start(fs_s)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CW(5)
    ) u_div1 (
        .clk(clk), .reset(rst), .enable(en),
        .h_sync(hs_1), .v_sync(vs_1), .video_on(vo_1),
        .x_loc(x_1), .y_loc(y_1),
        .pix_tick(pt_1), .line_start(ls_1), .frame_start(fs_1)
    );

    vga_timing_gen u_def (
        .clk(clk), .reset(rst), .enable(en),
        .h_sync(hs_d), .v_sync(vs_d), .video_on(vo_d),
        .x_loc(x_d), .y_loc(y_d),
        .pix_tick(pt_d), .line_start(ls_d), .frame_start(fs_d)
    );

    // Raster position = (number of advances - 1) mod frame size; advances = enabled clocks / divider.
    function automatic obs_t model(int ecnt, bit stp, bit r, int dv,
                                   int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb,
                                   bit hp, bit vp);
        obs_t o;
        int ht, vt, n, pos, x, y;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (r) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            n   = ecnt / dv;
            pos = (n + ht * vt - 1) % (ht * vt);
            x   = pos % ht;
            y   = pos / ht;
        end
        o.x  = 16'(x);
        o.y  = 16'(y);
        o.hs = (!r && x >= ha + hf && x < ha + hf + hsw) ? hp : ~hp;
        o.vs = (!r && y >= va + vf && y < va + vf + vsw) ? vp : ~vp;
        o.vo = !r && (x < ha) && (y < va);
        o.pt = !r && stp && (ecnt % dv == 0);
        o.ls = o.pt && (x == 0);
        o.fs = o.ls && (y == 0);
        return o;
    endfunction

    task automatic chk_obs(string nm, obs_t act, obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got x=%0d y=%0d hs/vs/vo/pt/ls/fs=%b%b%b%b%b%b expected x=%0d y=%0d hs/vs/vo/pt/ls/fs=%b%b%b%b%b%b",
                     nm, cyc, act.x, act.y, act.hs, act.vs, act.vo, act.pt, act.ls, act.fs,
                     exp.x, exp.y, exp.hs, exp.vs, exp.vo, exp.pt, exp.ls, exp.fs);
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            e       <= 0;
            stepped <= 1'b0;
        end else if (en) begin
            e       <= e + 1;
            stepped <= 1'b1;
        end else begin
            stepped <= 1'b0;
        end
    end

    always @(negedge clk) begin
        obs_t a;
        a = '{x: 16'(x_s), y: 16'(y_s), hs: hs_s, vs: vs_s, vo: vo_s, pt: pt_s, ls: ls_s, fs: fs_s};
        chk_obs("small", a, model(e, stepped, rst, 2, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0));
        a = '{x: 16'(x_1), y: 16'(y_1), hs: hs_1, vs: vs_1, vo: vo_1, pt: pt_1, ls: ls_1, fs: fs_1};
        chk_obs("div1", a, model(e, stepped, rst, 1, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b0));
        a = '{x: 16'(x_d), y: 16'(y_d), hs: hs_d, vs: vs_d, vo: vo_d, pt: pt_d, ls: ls_d, fs: fs_d};
        chk_obs("default", a, model(e, stepped, rst, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got no finish expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int hs_lo, vs_lo, vo_hi, fs_n, ls_n, pt1_n, hs1_hi, last_fs, last_ls;
        int t0, hold_x, hold_y, found, xmax, lsd_n;

        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x_s", int'(x_s), 15);
        chk("rst_y_s", int'(y_s), 7);
        chk("rst_hs_s", int'(hs_s), 1);
        chk("rst_vs_s", int'(vs_s), 1);
        chk("rst_vo_s", int'(vo_s), 0);
        chk("rst_pt_s", int'(pt_s), 0);
        chk("rst_x_1", int'(x_1), 15);
        chk("rst_hs_1", int'(hs_1), 0);
        chk("rst_x_d", int'(x_d), 799);
        chk("rst_y_d", int'(y_d), 524);
        chk("rst_hs_d", int'(hs_d), 1);

        rst = 1'b0;
        @(posedge clk); #1;
        chk("edge1_x_s", int'(x_s), 15);
        chk("edge1_pt_s", int'(pt_s), 0);
        chk("edge1_x_1", int'(x_1), 0);
        chk("edge1_fs_1", int'(fs_1), 1);
        @(posedge clk); #1;
        chk("edge2_x_s", int'(x_s), 0);
        chk("edge2_y_s", int'(y_s), 0);
        chk("edge2_vo_s", int'(vo_s), 1);
        chk("edge2_fs_s", int'(fs_s), 1);
        chk("edge2_ls_s", int'(ls_s), 1);
        chk("edge2_pt_s", int'(pt_s), 1);
        chk("edge2_x_1", int'(x_1), 1);
        chk("edge2_fs_1", int'(fs_1), 0);

        hs_lo = 0; vs_lo = 0; vo_hi = 0; fs_n = 0; ls_n = 0; pt1_n = 0; hs1_hi = 0;
        last_fs = -1; last_ls = -1;
        for (int i = 0; i < 768; i++) begin
            if (!hs_s) hs_lo++;
            if (!vs_s) vs_lo++;
            if (vo_s) vo_hi++;
            if (pt_1) pt1_n++;
            if (hs_1) hs1_hi++;
            if (fs_s) begin
                if (last_fs >= 0) chk("fs_period", cyc - last_fs, 256);
                last_fs = cyc;
                fs_n++;
            end
            if (ls_s) begin
                if (last_ls >= 0) chk("ls_period", cyc - last_ls, 32);
                last_ls = cyc;
                ls_n++;
            end
            @(posedge clk); #1;
        end
        chk("hs_low_clks_3f", hs_lo, 144);
        chk("vs_low_clks_3f", vs_lo, 192);
        chk("vo_high_clks_3f", vo_hi, 192);
        chk("fs_count_3f", fs_n, 3);
        chk("ls_count_3f", ls_n, 24);
        chk("div1_pt_high", pt1_n, 768);
        chk("div1_hs_high", hs1_hi, 144);

        for (int k = 0; k < 300 && !fs_s; k++) begin
            @(posedge clk); #1;
        end
        chk("fs_before_pause", int'(fs_s), 1);
        t0 = cyc;
        @(posedge clk); #1;
        en = 1'b0;
        hold_x = int'(x_s);
        hold_y = int'(y_s);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("pause_x", int'(x_s), hold_x);
            chk("pause_y", int'(y_s), hold_y);
            chk("pause_pt", int'(pt_s), 0);
            chk("pause_pt_1", int'(pt_1), 0);
        end
        en = 1'b1;
        @(posedge clk); #1;
        chk("resume_pt", int'(pt_s), 1);
        chk("resume_x", int'(x_s), hold_x + 1);
        for (int k = 0; k < 400 && !fs_s; k++) begin
            @(posedge clk); #1;
        end
        chk("fs_period_pause", cyc - t0, 261);

        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            if (x_s == 5'd9 && y_s == 5'd3) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("found_x9_y3", found, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_x_s", int'(x_s), 15);
        chk("async_y_s", int'(y_s), 7);
        chk("async_hs_s", int'(hs_s), 1);
        chk("async_vs_s", int'(vs_s), 1);
        chk("async_vo_s", int'(vo_s), 0);
        chk("async_pt_s", int'(pt_s), 0);
        chk("async_x_d", int'(x_d), 799);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("restart1_x_s", int'(x_s), 15);
        @(posedge clk); #1;
        chk("restart2_x_s", int'(x_s), 0);
        chk("restart2_y_s", int'(y_s), 0);
        chk("restart2_fs_s", int'(fs_s), 1);
        chk("restart2_vo_s", int'(vo_s), 1);

        xmax = 0;
        lsd_n = 0;
        for (int i = 0; i < 3300; i++) begin
            if (int'(x_d) > xmax) xmax = int'(x_d);
            if (ls_d) lsd_n++;
            @(posedge clk); #1;
        end
        chk("default_x_max", xmax, 799);
        chk("default_ls_count", lsd_n, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
